sm_key_input: RTL and testbench
===============================

// Module: sm_key_input
// PURPOSE
//  Board-side input path for the schoolRISCV board tops: the key-to-core
//  direction, complementing the LED/register-display output path.
//  Synchronises raw active-low push-buttons, debounces them, and produces level,
//  press/release/long-press pulses plus sticky event flags.
//  The core (or a memory-mapped port) reads these, and software clears them.
//  Sits between the board KEYx pins and sm_top; one instance per board top.
// PARAMETERS
//  KEY_COUNT    2            number of keys handled
//  DEB_CYCLES   1000000      cycles input must differ stably before state flips (10 ms @100 MHz)
//  DEB_W        20           debounce counter width; must hold DEB_CYCLES-1
//  LONG_CYCLES  100000000    cycles held (after debounced press) for long-press event (1 s)
//  LONG_W       27           hold counter width; must hold LONG_CYCLES
// PORTS
//  clk       in   1          system clock, all logic on rising edge
//  rst_n     in   1          asynchronous active-low reset
//  keyIn_n   in   KEY_COUNT  raw board keys, active-low, asynchronous, bouncy
//  evtClr    in   KEY_COUNT  per-key clear of sticky flags (1 = clear), sampled every clk
//  keyState  out  KEY_COUNT  debounced level, 1 = pressed
//  keyPress  out  KEY_COUNT  1-cycle pulse on debounced press
//  keyRelease out KEY_COUNT  1-cycle pulse on debounced release
//  keyLong   out  KEY_COUNT  1-cycle pulse when hold reaches LONG_CYCLES
//  evtPress  out  KEY_COUNT  sticky: press seen since last clear
//  evtLong   out  KEY_COUNT  sticky: long press seen since last clear
// BEHAVIOUR
//  Reset (async, rst_n=0): sync flops <= 1 (released), all counters <= 0,
//   every output <= 0 immediately; reset mid-debounce/mid-hold discards progress.
//  Sync: per key, 2-flop synchroniser on keyIn_n, inverted to active-high s[i].
//  Debounce (per key, independent):
//   - s[i]==keyState[i]: debCnt <= 0.
//   - s[i]!=keyState[i] and debCnt<DEB_CYCLES-1: debCnt <= debCnt+1.
//   - s[i]!=keyState[i] and debCnt==DEB_CYCLES-1: keyState[i] toggles, debCnt <= 0.
//   - Any bounce back to equality restarts count from 0.
//   - Latency: keyState changes DEB_CYCLES+2 edges after a clean raw edge
//     (2 sync + DEB_CYCLES stable).
//  Pulses: keyPress/keyRelease registered; high exactly in the first cycle
//   keyState shows the new level; never both high for one key.
//  Long press: holdCnt clears while keyState=0; increments each cycle
//   keyState=1, saturating at LONG_CYCLES. keyLong pulses in the cycle holdCnt
//   reaches LONG_CYCLES (LONG_CYCLES cycles after keyPress). Once per hold; the
//   next long pulse requires release + new press.
//  Sticky flags: evtPress[i] set by keyPress[i], evtLong[i] set by keyLong[i];
//   both cleared by evtClr[i] next edge. Set and clear in same cycle -> set wins.
//  Keys fully independent; simultaneous events on different keys all reported.
//  No combinational path from inputs to outputs.
// TESTING (bench params: KEY_COUNT=2, DEB_CYCLES=4, DEB_W=3, LONG_CYCLES=20, LONG_W=5)
//  1 Reset with keyIn_n=2'b11 -> all outputs 0; stay 0 for 100 cycles idle.
//  2 keyIn_n[0] 1->0 clean at edge T -> keyState[0]=1 and keyPress[0] one-cycle
//    pulse at T+6; key1 outputs and keyRelease stay 0.
//  3 keyIn_n[1] toggles every 3 cycles for 30 cycles, then held 0 -> no pulse
//    during bounce; exactly one keyPress[1], 6 cycles after final edge.
//  4 Hold key0 -> keyLong[0] single pulse 20 cycles after keyPress[0], none after;
//    release -> keyRelease[0] at +6. A 10-cycle hold gives no keyLong.
//  5 evtPress[0] set after press; evtClr[0]=1 alone -> 0 next cycle; evtClr[0]
//    in same cycle as keyPress[0] -> evtPress[0] stays 1.
//  6 rst_n low mid-debounce (debCnt=3) -> outputs 0 at once; release rst_n with
//    key still held -> keyPress after full 6 cycles, not earlier.

Source files
------------

// File: rtl/sm_key_input.sv
// Board push-button front end: synchronises and debounces active-low keys and
// turns them into level, press/release/long-press pulses and software-cleared sticky flags.
module sm_key_input #(
    parameter int KEY_COUNT   = 2,
    parameter int DEB_CYCLES  = 1000000,
    parameter int DEB_W       = 20,
    parameter int LONG_CYCLES = 100000000,
    parameter int LONG_W      = 27
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [KEY_COUNT-1:0] keyIn_n,
    input  logic [KEY_COUNT-1:0] evtClr,
    output logic [KEY_COUNT-1:0] keyState,
    output logic [KEY_COUNT-1:0] keyPress,
    output logic [KEY_COUNT-1:0] keyRelease,
    output logic [KEY_COUNT-1:0] keyLong,
    output logic [KEY_COUNT-1:0] evtPress,
    output logic [KEY_COUNT-1:0] evtLong
);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_PRE  = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < KEY_COUNT; gi = gi + 1) begin : g_key
            logic              sync1_q, sync1_d;
            logic              sync2_q, sync2_d;
            logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
            logic              state_q, state_d;
            logic              press_q, press_d;
            logic              release_q, release_d;
            logic [LONG_W-1:0] hold_cnt_q, hold_cnt_d;
            logic              long_q, long_d;
            logic              evt_press_q, evt_press_d;
            logic              evt_long_q, evt_long_d;
            logic              s_act;
            logic              flip;

            // Synchronised key, converted to active-high (1 = pressed).
            assign s_act = ~sync2_q;
            assign flip  = (s_act != state_q) && (deb_cnt_q == DEB_LAST);

            always_comb begin
                sync1_d     = keyIn_n[gi];
                sync2_d     = sync1_q;
                deb_cnt_d   = '0;
                state_d     = state_q;
                if (s_act != state_q) begin
                    if (flip) begin
                        state_d   = ~state_q;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_ONE;
                    end
                end

                press_d     = flip && !state_q;
                release_d   = flip && state_q;

                // Hold counter runs on the debounced level and parks at the limit
                // so the long pulse fires only once per hold.
                if (!state_q) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == LONG_MAX) begin
                    hold_cnt_d = hold_cnt_q;
                end else begin
                    hold_cnt_d = hold_cnt_q + LONG_ONE;
                end
                long_d      = state_q && (hold_cnt_q == LONG_PRE);

                evt_press_d = evt_press_q;
                evt_long_d  = evt_long_q;
                if (evtClr[gi]) begin
                    evt_press_d = 1'b0;
                    evt_long_d  = 1'b0;
                end
                if (press_q) evt_press_d = 1'b1;
                if (long_q)  evt_long_d  = 1'b1;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_q     <= 1'b1;
                    sync2_q     <= 1'b1;
                    deb_cnt_q   <= '0;
                    state_q     <= 1'b0;
                    press_q     <= 1'b0;
                    release_q   <= 1'b0;
                    hold_cnt_q  <= '0;
                    long_q      <= 1'b0;
                    evt_press_q <= 1'b0;
                    evt_long_q  <= 1'b0;
                end else begin
                    sync1_q     <= sync1_d;
                    sync2_q     <= sync2_d;
                    deb_cnt_q   <= deb_cnt_d;
                    state_q     <= state_d;
                    press_q     <= press_d;
                    release_q   <= release_d;
                    hold_cnt_q  <= hold_cnt_d;
                    long_q      <= long_d;
                    evt_press_q <= evt_press_d;
                    evt_long_q  <= evt_long_d;
                end
            end

            assign keyState[gi]   = state_q;
            assign keyPress[gi]   = press_q;
            assign keyRelease[gi] = release_q;
            assign keyLong[gi]    = long_q;
            assign evtPress[gi]   = evt_press_q;
            assign evtLong[gi]    = evt_long_q;
        end
    endgenerate

endmodule

// File: tb/tb_sm_key_input.sv
// Directed bench for sm_key_input with short debounce/long-press windows;
// inputs change 1 ns after a rising edge and outputs are sampled there too.
module tb_sm_key_input;

    logic       clk;
    logic       rst_n;
    logic [1:0] keyIn_n;
    logic [1:0] evtClr;
    logic [1:0] keyState, keyPress, keyRelease, keyLong, evtPress, evtLong;
    logic [11:0] all_out;

    int total;
    int bad;

    sm_key_input #(
        .KEY_COUNT(2), .DEB_CYCLES(4), .DEB_W(3), .LONG_CYCLES(20), .LONG_W(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .keyIn_n(keyIn_n), .evtClr(evtClr),
        .keyState(keyState), .keyPress(keyPress), .keyRelease(keyRelease),
        .keyLong(keyLong), .evtPress(evtPress), .evtLong(evtLong)
    );

    assign all_out = {keyState, keyPress, keyRelease, keyLong, evtPress, evtLong};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; keyIn_n = 2'b11; evtClr = 2'b00;
        #3;
        total++;
        if (all_out !== 12'h000) begin
            bad++; $display("FAIL reset_outputs got=%h want=000", all_out);
        end
        step(); step();
        rst_n = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            total++;
            if (all_out !== 12'h000) begin
                bad++; $display("FAIL idle_outputs cyc=%0d got=%h want=000", k, all_out);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_press();
        keyIn_n[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            total++;
            if (keyPress[0] !== (k == 6)) begin
                bad++; $display("FAIL press0_pulse cyc=%0d got=%b want=%b", k, keyPress[0], (k == 6));
            end
            total++;
            if (keyState[0] !== (k >= 6)) begin
                bad++; $display("FAIL press0_state cyc=%0d got=%b want=%b", k, keyState[0], (k >= 6));
            end
            total++;
            if ({keyState[1], keyPress[1], keyRelease, keyLong} !== 6'b0) begin
                bad++; $display("FAIL press0_others cyc=%0d got=%b want=000000", k,
                                {keyState[1], keyPress[1], keyRelease, keyLong});
            end
        end
        keyIn_n[0] = 1'b1;
        repeat (12) step();
        $display("test_press done");
    endtask

    task automatic test_bounce();
        int presses;
        presses = 0;
        for (int t = 0; t < 10; t++) begin
            keyIn_n[1] = ~keyIn_n[1];
            for (int c = 0; c < 3; c++) begin
                step();
                total++;
                if (keyPress[1] !== 1'b0 || keyState[1] !== 1'b0) begin
                    bad++; $display("FAIL bounce_quiet t=%0d got press=%b state=%b want 0/0",
                                    t, keyPress[1], keyState[1]);
                end
            end
        end
        keyIn_n[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (keyPress[1] === 1'b1) presses++;
            total++;
            if (keyPress[1] !== (k == 6)) begin
                bad++; $display("FAIL bounce_press cyc=%0d got=%b want=%b", k, keyPress[1], (k == 6));
            end
        end
        total++;
        if (presses != 1) begin
            bad++; $display("FAIL bounce_count got=%0d want=1", presses);
        end
        keyIn_n[1] = 1'b1;
        repeat (12) step();
        $display("test_bounce done");
    endtask

    task automatic test_long();
        int longs;
        keyIn_n[0] = 1'b0;
        repeat (6) step();
        total++;
        if (keyPress[0] !== 1'b1) begin
            bad++; $display("FAIL long_press got=%b want=1", keyPress[0]);
        end
        for (int k = 1; k <= 25; k++) begin
            step();
            total++;
            if (keyLong[0] !== (k == 20)) begin
                bad++; $display("FAIL long_pulse cyc=%0d got=%b want=%b", k, keyLong[0], (k == 20));
            end
            if (k == 21) begin
                total++;
                if (evtLong[0] !== 1'b1) begin
                    bad++; $display("FAIL long_sticky got=%b want=1", evtLong[0]);
                end
            end
        end
        keyIn_n[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            total++;
            if (keyRelease[0] !== (k == 6) || keyLong[0] !== 1'b0) begin
                bad++; $display("FAIL long_release cyc=%0d got rel=%b long=%b want %b/0",
                                k, keyRelease[0], keyLong[0], (k == 6));
            end
        end
        // A hold well short of the long threshold.
        keyIn_n[0] = 1'b0;
        repeat (6) step();
        repeat (4) step();
        keyIn_n[0] = 1'b1;
        longs = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (keyLong[0] === 1'b1) longs++;
        end
        total++;
        if (longs != 0 || keyState[0] !== 1'b0) begin
            bad++; $display("FAIL short_hold got longs=%0d state=%b want 0/0", longs, keyState[0]);
        end
        $display("test_long done");
    endtask

    task automatic test_sticky();
        total++;
        if (evtPress[0] !== 1'b1) begin
            bad++; $display("FAIL sticky_set got=%b want=1", evtPress[0]);
        end
        evtClr = 2'b01;
        step();
        evtClr = 2'b00;
        total++;
        if (evtPress[0] !== 1'b0 || evtLong[0] !== 1'b0) begin
            bad++; $display("FAIL sticky_clear got press=%b long=%b want 0/0", evtPress[0], evtLong[0]);
        end
        total++;
        if (evtPress[1] !== 1'b1) begin
            bad++; $display("FAIL sticky_other got=%b want=1", evtPress[1]);
        end
        step();
        total++;
        if (evtPress[0] !== 1'b0) begin
            bad++; $display("FAIL sticky_stays_clear got=%b want=0", evtPress[0]);
        end
        keyIn_n[0] = 1'b0;
        repeat (6) step();
        total++;
        if (keyPress[0] !== 1'b1 || evtPress[0] !== 1'b0) begin
            bad++; $display("FAIL sticky_pre got press=%b evt=%b want 1/0", keyPress[0], evtPress[0]);
        end
        evtClr = 2'b01;
        step();
        evtClr = 2'b00;
        total++;
        if (evtPress[0] !== 1'b1) begin
            bad++; $display("FAIL sticky_set_wins got=%b want=1", evtPress[0]);
        end
        keyIn_n[0] = 1'b1;
        repeat (12) step();
        $display("test_sticky done");
    endtask

    task automatic test_async_reset();
        keyIn_n[0] = 1'b0;
        repeat (5) step();
        total++;
        if (keyState[0] !== 1'b0 || evtPress[1] !== 1'b1) begin
            bad++; $display("FAIL arst_pre got state=%b evt1=%b want 0/1", keyState[0], evtPress[1]);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (all_out !== 12'h000) begin
            bad++; $display("FAIL arst_outputs got=%h want=000", all_out);
        end
        step(); step();
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            total++;
            if (keyPress[0] !== (k == 6) || keyState[0] !== (k >= 6)) begin
                bad++; $display("FAIL arst_restart cyc=%0d got press=%b state=%b want %b/%b",
                                k, keyPress[0], keyState[0], (k == 6), (k >= 6));
            end
        end
        $display("test_async_reset done");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_press();
        test_bounce();
        test_long();
        test_sticky();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
